lna_power_sequencer: RTL and testbench
======================================

LNA_POWER_SEQUENCER -- requirements
Module: lna_power_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports Clock100Mhz and Reset.
REQ-002 Parameter SETTLE_CYCLES, default 1000: bias settle time in clocks (10 us at 100 MHz).
REQ-003 Parameter RAMP_DIV, default 100: clocks per VplusDuty step.
REQ-004 Parameter FAULT_FILTER, default 4: consecutive fault-high clocks required to trip.
REQ-005 Clock100Mhz  in  1  sole clock, rising edge.
REQ-006 Reset  in  1  synchronous, active-high.
REQ-007 PowerRequest  in  1  level; 1 requests LNA powered.
REQ-008 ClockLocked  in  1  100 MHz clock generator locked.
REQ-009 FaultVplus / FaultVminus  in  1 each  supply comparator fault, active-high, already synchronous.
REQ-010 FaultClear  in  1  single-cycle fault acknowledge.
REQ-011 EnableVminus  out  1  negative gate-bias supply enable.
REQ-012 EnableVplus  out  1  positive drain supply enable.
REQ-013 VplusDuty  out  8  soft-start PWM duty for positive supply.
REQ-014 PowerGood  out  1  high only in READY.
REQ-015 FaultCode  out  2  0 none, 1 Vplus, 2 Vminus, 3 both.
REQ-016 State  out  3  current state encoding.

Function
REQ-017 States SHALL be OFF=0, WAIT_LOCK=1, NEG_SETTLE=2, RAMP_UP=3, READY=4, RAMP_DOWN=5, NEG_HOLD=6, FAULT=7; all outputs are registered.
REQ-018 OFF: PowerRequest&ClockLocked -> NEG_SETTLE with EnableVminus=1; PowerRequest&!ClockLocked -> WAIT_LOCK.
REQ-019 WAIT_LOCK: ClockLocked -> NEG_SETTLE; PowerRequest low -> OFF.
REQ-020 EnableVplus SHALL assert exactly SETTLE_CYCLES clocks after EnableVminus asserts, on entry to RAMP_UP, with VplusDuty=0.
REQ-021 RAMP_UP: VplusDuty increments by 1 every RAMP_DIV clocks, saturating at 255; entry to READY on the clock after duty reaches 255.
REQ-022 READY: PowerGood=1; PowerRequest low or ClockLocked low -> RAMP_DOWN.
REQ-023 RAMP_UP with PowerRequest or ClockLocked low -> RAMP_DOWN from the current duty, no step skipped; NEG_SETTLE with same condition -> NEG_HOLD.
REQ-024 RAMP_DOWN: duty decrements by 1 every RAMP_DIV clocks; at 0, EnableVplus=0 and -> NEG_HOLD; PowerRequest re-asserting SHALL NOT reverse the ramp.
REQ-025 NEG_HOLD: after SETTLE_CYCLES clocks EnableVminus=0 -> OFF; EnableVplus never high while EnableVminus low.
REQ-026 A fault input high FAULT_FILTER consecutive clocks in NEG_SETTLE..NEG_HOLD SHALL enter FAULT; a shorter pulse is ignored and resets its filter.
REQ-027 On FAULT entry: EnableVplus=0, VplusDuty=0, PowerGood=0 in the same clock; FaultCode latched; EnableVminus held SETTLE_CYCLES then cleared, or cleared immediately if FaultVminus tripped.
REQ-028 FAULT exits to OFF only on FaultClear with PowerRequest low and the hold timer expired; FaultCode clears then; FaultClear otherwise ignored.
REQ-029 Simultaneous fault trip and PowerRequest change: fault wins.

Reset
REQ-030 Reset SHALL force State=OFF, all enables 0, VplusDuty=0, PowerGood=0, FaultCode=0, timers and filters cleared, including mid-ramp, with no shutdown sequencing.

Structure
REQ-031 Package lna_power_pkg SHALL hold the state encoding, FaultCode constants and duty width.
REQ-032 Sub-module lna_fault_filter (counter debounce, FAULT_FILTER parameter) SHALL be instantiated once per fault input.

Verification (SETTLE_CYCLES=8, RAMP_DIV=2, FAULT_FILTER=4)
REQ-033 PowerRequest=1, ClockLocked=1 -> EnableVminus at +1, EnableVplus 8 clocks later, duty 255 after 510 more clocks, then PowerGood=1.
REQ-034 Drop PowerRequest in READY -> duty reaches 0 in 510 clocks, EnableVplus=0, EnableVminus=0 8 clocks later, State=OFF.
REQ-035 FaultVplus high 3 clocks in RAMP_UP -> no trip; high 4 clocks -> FAULT, duty 0, FaultCode=1, EnableVminus low 8 clocks later.
REQ-036 In FAULT, FaultClear with PowerRequest=1 -> stays FAULT; PowerRequest=0 then FaultClear -> OFF, FaultCode=0.
REQ-037 ClockLocked low at request -> WAIT_LOCK, no enables until lock; Reset at duty 100 -> all outputs 0 next clock.

Source files
------------

// File: rtl/lna_power_pkg.sv
// Shared types and constants for the LNA power sequencer.
// State encoding, fault codes and duty width.
package lna_power_pkg;

    localparam int DUTY_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        S_OFF        = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_NEG_SETTLE = 3'd2,
        S_RAMP_UP    = 3'd3,
        S_READY      = 3'd4,
        S_RAMP_DOWN  = 3'd5,
        S_NEG_HOLD   = 3'd6,
        S_FAULT      = 3'd7
    } state_e;

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_VPLUS  = 2'd1;
    localparam logic [1:0] FC_VMINUS = 2'd2;
    localparam logic [1:0] FC_BOTH   = 2'd3;

    function automatic logic [1:0] fault_code(input logic vp, input logic vm);
        if (vp && vm) return FC_BOTH;
        if (vm)       return FC_VMINUS;
        if (vp)       return FC_VPLUS;
        return FC_NONE;
    endfunction

endpackage

// File: rtl/lna_power_sequencer_if.sv
// Control/status bundle between the system and the LNA sequencer.
// master drives requests and faults; slave is the sequencer.
interface lna_power_sequencer_if;
    import lna_power_pkg::*;

    logic               PowerRequest;
    logic               ClockLocked;
    logic               FaultVplus;
    logic               FaultVminus;
    logic               FaultClear;
    logic               EnableVminus;
    logic               EnableVplus;
    logic [DUTY_W-1:0]  VplusDuty;
    logic               PowerGood;
    logic [1:0]         FaultCode;
    logic [STATE_W-1:0] State;

    modport master (
        output PowerRequest, ClockLocked, FaultVplus, FaultVminus, FaultClear,
        input  EnableVminus, EnableVplus, VplusDuty, PowerGood, FaultCode, State
    );

    modport slave (
        input  PowerRequest, ClockLocked, FaultVplus, FaultVminus, FaultClear,
        output EnableVminus, EnableVplus, VplusDuty, PowerGood, FaultCode, State
    );

endinterface

// File: rtl/lna_fault_filter.sv
// Debounce for one supply fault comparator: trips on the
// FAULT_FILTER-th consecutive high clock while enabled.
module lna_fault_filter #(
    parameter int FAULT_FILTER = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic fault_i,
    output logic trip_o
);

    localparam int CW = $clog2(FAULT_FILTER + 1);
    localparam logic [CW-1:0] C_LAST = CW'(FAULT_FILTER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign trip_o = en_i && fault_i && (cnt_q == C_LAST);

    // Count consecutive fault clocks; any gap or disable restarts.
    always_comb begin
        cnt_d = '0;
        if (en_i && fault_i && !trip_o) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lna_power_sequencer.sv
// LNA bias/drain power sequencer: Vminus first, soft-start Vplus,
// symmetric shutdown, filtered supply fault handling.
module lna_power_sequencer
    import lna_power_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int RAMP_DIV      = 100,
    parameter int FAULT_FILTER  = 4
) (
    input  logic                Clock100Mhz,
    input  logic                Reset,
    lna_power_sequencer_if.slave seq_io
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(RAMP_DIV + 1);
    localparam logic [TW-1:0] T_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_DONE = TW'(SETTLE_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(RAMP_DIV - 1);

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DW-1:0]     div_q, div_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              vminus_q, vminus_d;
    logic              vplus_q, vplus_d;
    logic              pgood_q, pgood_d;
    logic [1:0]        fcode_q, fcode_d;

    logic flt_en, trip_vp, trip_vm, drop;

    assign flt_en = (state_q >= S_NEG_SETTLE) && (state_q <= S_NEG_HOLD);
    assign drop   = !seq_io.PowerRequest || !seq_io.ClockLocked;

    lna_fault_filter #(.FAULT_FILTER(FAULT_FILTER)) u_flt_vp (
        .clk_i   (Clock100Mhz),
        .rst_i   (Reset),
        .en_i    (flt_en),
        .fault_i (seq_io.FaultVplus),
        .trip_o  (trip_vp)
    );

    lna_fault_filter #(.FAULT_FILTER(FAULT_FILTER)) u_flt_vm (
        .clk_i   (Clock100Mhz),
        .rst_i   (Reset),
        .en_i    (flt_en),
        .fault_i (seq_io.FaultVminus),
        .trip_o  (trip_vm)
    );

    // Next state and registered outputs; a fault trip overrides all.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = div_q;
        duty_d   = duty_q;
        vminus_d = vminus_q;
        vplus_d  = vplus_q;
        pgood_d  = 1'b0;
        fcode_d  = fcode_q;
        if (trip_vp || trip_vm) begin
            state_d = S_FAULT;
            timer_d = '0;
            div_d   = '0;
            duty_d  = '0;
            vplus_d = 1'b0;
            fcode_d = fault_code(trip_vp, trip_vm);
            if (trip_vm) vminus_d = 1'b0;
        end else begin
            unique case (state_q)
                S_OFF, S_WAIT_LOCK: begin
                    if (!seq_io.PowerRequest) begin
                        state_d = S_OFF;
                    end else if (seq_io.ClockLocked) begin
                        state_d  = S_NEG_SETTLE;
                        vminus_d = 1'b1;
                        timer_d  = '0;
                    end else begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_NEG_SETTLE: begin
                    if (drop) begin
                        state_d = S_NEG_HOLD;
                        timer_d = '0;
                    end else if (timer_q == T_LAST) begin
                        state_d = S_RAMP_UP;
                        vplus_d = 1'b1;
                        duty_d  = '0;
                        div_d   = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_RAMP_UP: begin
                    if (drop) begin
                        state_d = S_RAMP_DOWN;
                        div_d   = '0;
                    end else if (duty_q == DUTY_MAX) begin
                        state_d = S_READY;
                        pgood_d = 1'b1;
                    end else if (div_q == D_LAST) begin
                        div_d  = '0;
                        duty_d = duty_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_READY: begin
                    if (drop) begin
                        state_d = S_RAMP_DOWN;
                        div_d   = '0;
                    end else begin
                        pgood_d = 1'b1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (duty_q == '0) begin
                        state_d = S_NEG_HOLD;
                        vplus_d = 1'b0;
                        timer_d = '0;
                    end else if (div_q == D_LAST) begin
                        div_d  = '0;
                        duty_d = duty_q - 1'b1;
                        if (duty_q == DUTY_W'(1)) begin
                            state_d = S_NEG_HOLD;
                            vplus_d = 1'b0;
                            timer_d = '0;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_NEG_HOLD: begin
                    if (timer_q == T_LAST) begin
                        state_d  = S_OFF;
                        vminus_d = 1'b0;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (timer_q != T_DONE) timer_d = timer_q + 1'b1;
                    if (timer_q == T_LAST) vminus_d = 1'b0;
                    if (seq_io.FaultClear && !seq_io.PowerRequest &&
                        timer_q == T_DONE) begin
                        state_d = S_OFF;
                        fcode_d = FC_NONE;
                        timer_d = '0;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset drops everything at once.
    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            state_q  <= S_OFF;
            timer_q  <= '0;
            div_q    <= '0;
            duty_q   <= '0;
            vminus_q <= 1'b0;
            vplus_q  <= 1'b0;
            pgood_q  <= 1'b0;
            fcode_q  <= FC_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            duty_q   <= duty_d;
            vminus_q <= vminus_d;
            vplus_q  <= vplus_d;
            pgood_q  <= pgood_d;
            fcode_q  <= fcode_d;
        end
    end

    assign seq_io.State        = state_q;
    assign seq_io.EnableVminus = vminus_q;
    assign seq_io.EnableVplus  = vplus_q;
    assign seq_io.VplusDuty    = duty_q;
    assign seq_io.PowerGood    = pgood_q;
    assign seq_io.FaultCode    = fcode_q;

endmodule

// File: tb/tb_lna_power_sequencer.sv
// Directed bench for lna_power_sequencer with short timing
// parameters (settle 8, ramp divide 2, fault filter 4).
module tb_lna_power_sequencer;

    logic Clock100Mhz;
    logic Reset;
    int   n_checks;
    int   n_errors;

    lna_power_sequencer_if bus();

    lna_power_sequencer #(
        .SETTLE_CYCLES (8),
        .RAMP_DIV      (2),
        .FAULT_FILTER  (4)
    ) dut (
        .Clock100Mhz (Clock100Mhz),
        .Reset       (Reset),
        .seq_io      (bus)
    );

    initial Clock100Mhz = 1'b0;
    always #5 Clock100Mhz = ~Clock100Mhz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int st, input int vm,
                               input int vp, input int duty, input int pg,
                               input int fc);
        check({tag, ".state"}, int'(bus.State), st);
        check({tag, ".vminus"}, int'(bus.EnableVminus), vm);
        check({tag, ".vplus"}, int'(bus.EnableVplus), vp);
        check({tag, ".duty"}, int'(bus.VplusDuty), duty);
        check({tag, ".pgood"}, int'(bus.PowerGood), pg);
        check({tag, ".fcode"}, int'(bus.FaultCode), fc);
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge Clock100Mhz);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        bus.PowerRequest = 1'b0;
        bus.ClockLocked  = 1'b0;
        bus.FaultVplus   = 1'b0;
        bus.FaultVminus  = 1'b0;
        bus.FaultClear   = 1'b0;
        step(2);
        expect_outs("reset", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        // Power-up sequence
        bus.PowerRequest = 1'b1;
        bus.ClockLocked  = 1'b1;
        step(1);
        expect_outs("neg_settle", 2, 1, 0, 0, 0, 0);
        step(7);
        check("settle_vp_low", int'(bus.EnableVplus), 0);
        check("settle_state", int'(bus.State), 2);
        step(1);
        expect_outs("ramp_entry", 3, 1, 1, 0, 0, 0);
        step(509);
        check("ramp_254", int'(bus.VplusDuty), 254);
        step(1);
        check("ramp_255", int'(bus.VplusDuty), 255);
        check("ramp_255_pg", int'(bus.PowerGood), 0);
        step(1);
        expect_outs("ready", 4, 1, 1, 255, 1, 0);

        // Shutdown; a re-request must not reverse the ramp
        bus.PowerRequest = 1'b0;
        step(1);
        expect_outs("down_entry", 5, 1, 1, 255, 0, 0);
        bus.PowerRequest = 1'b1;
        step(10);
        check("down_norev_state", int'(bus.State), 5);
        check("down_norev_duty", int'(bus.VplusDuty), 250);
        bus.PowerRequest = 1'b0;
        step(499);
        check("down_duty1", int'(bus.VplusDuty), 1);
        check("down_vp_on", int'(bus.EnableVplus), 1);
        step(1);
        expect_outs("down_zero", 6, 1, 0, 0, 0, 0);
        step(7);
        check("hold_vm", int'(bus.EnableVminus), 1);
        step(1);
        expect_outs("off", 0, 0, 0, 0, 0, 0);

        // Vplus fault filter in RAMP_UP
        bus.PowerRequest = 1'b1;
        step(9);
        check("ramp2_state", int'(bus.State), 3);
        step(20);
        check("ramp2_duty", int'(bus.VplusDuty), 10);
        bus.FaultVplus = 1'b1;
        step(3);
        bus.FaultVplus = 1'b0;
        step(2);
        check("glitch_state", int'(bus.State), 3);
        bus.FaultVplus = 1'b1;
        step(3);
        check("filter3_state", int'(bus.State), 3);
        step(1);
        expect_outs("vp_fault", 7, 1, 0, 0, 0, 1);
        bus.FaultVplus = 1'b0;
        step(7);
        check("fault_vm_held", int'(bus.EnableVminus), 1);
        step(1);
        check("fault_vm_off", int'(bus.EnableVminus), 0);
        bus.FaultClear = 1'b1;
        step(1);
        bus.FaultClear = 1'b0;
        check("clr_req_state", int'(bus.State), 7);
        check("clr_req_fc", int'(bus.FaultCode), 1);
        bus.PowerRequest = 1'b0;
        step(1);
        check("noclr_state", int'(bus.State), 7);
        bus.FaultClear = 1'b1;
        step(1);
        bus.FaultClear = 1'b0;
        expect_outs("cleared", 0, 0, 0, 0, 0, 0);

        // Vminus fault in NEG_SETTLE drops bias at once
        bus.PowerRequest = 1'b1;
        step(1);
        check("settle2_state", int'(bus.State), 2);
        bus.FaultVminus = 1'b1;
        step(4);
        expect_outs("vm_fault", 7, 0, 0, 0, 0, 2);
        bus.FaultVminus = 1'b0;
        bus.PowerRequest = 1'b0;
        bus.FaultClear = 1'b1;
        step(1);
        bus.FaultClear = 1'b0;
        check("early_clr_state", int'(bus.State), 7);
        step(8);
        bus.FaultClear = 1'b1;
        step(1);
        bus.FaultClear = 1'b0;
        check("late_clr_state", int'(bus.State), 0);
        check("late_clr_fc", int'(bus.FaultCode), 0);

        // Wait for clock lock
        bus.ClockLocked  = 1'b0;
        bus.PowerRequest = 1'b1;
        step(1);
        expect_outs("wait_lock", 1, 0, 0, 0, 0, 0);
        step(3);
        check("wait_lock_hold", int'(bus.State), 1);
        check("wait_lock_vm", int'(bus.EnableVminus), 0);
        bus.ClockLocked = 1'b1;
        step(1);
        check("locked_state", int'(bus.State), 2);
        check("locked_vm", int'(bus.EnableVminus), 1);

        // Reset mid-ramp
        step(8);
        step(200);
        check("mid_duty", int'(bus.VplusDuty), 100);
        Reset = 1'b1;
        step(1);
        expect_outs("reset_mid", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        bus.PowerRequest = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
